ifm_bank_writer_cu: RTL and testbench
=====================================

Name: ifm_bank_writer_cu

Overview:
- Upstream-side (writer) controller for the multi-bank IFM buffer that a convolution control unit reads.
- Accepts a pixel stream from the previous layer and writes each depth slice into one of NUM_BANKS banks.
- Pulses start_to_next once per filled bank and obeys the consumer's end/ready handshake, so that no bank still being re-read across filter passes is overwritten.
- Its bank pointer advances in lockstep with the consumer's per-start bank selector.

Parameters:
- DATA_WIDTH, 32, pixel width.
- IFM_SIZE, 13, IFM edge; each bank holds IFM_SIZE*IFM_SIZE words.
- NUM_BANKS, 6, banks per image (depth slices per unit group).
- NUMBER_OF_FILTERS, 28, consumer filter passes per image; 1 disables the busy-observe rule.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), bank address width.
- BANK_SEL_WIDTH, $clog2(NUM_BANKS), bank select width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_data  in  DATA_WIDTH  input pixel
- in_ready  out  1  writer can accept a pixel this cycle
- mem_write_enable  out  1  registered bank write strobe
- mem_write_address  out  ADDRESS_SIZE_IFM  registered write address
- mem_write_data  out  DATA_WIDTH  registered write data
- bank_sel_write  out  BANK_SEL_WIDTH  bank currently being written
- start_to_next  out  1  one-cycle pulse: bank bank_sel_write is complete
- end_from_next  in  1  consumer idle/finished current bank (high when it can take a start)
- next_ready  in  1  consumer is in filter pass 0 (low while self-restarting passes 1..N-1)
- image_done  out  1  one-cycle pulse with the handoff of bank NUM_BANKS-1

Behaviour:
- Clock and reset: clk; reset is asynchronous and active-high.
- Reset values: state=WRITE, addr counter=0, bank_sel_write=0, in_ready=1, mem_write_enable=0, mem_write_address=0, mem_write_data=0, start_to_next=0, image_done=0, seen_busy=0.
- States:
  - WRITE: in_ready=1. An accept is in_valid&in_ready. Each accept increments the addr counter.
  - WRITE → WAIT_END: on an accept when the addr counter is IFM_SIZE*IFM_SIZE-1. The addr counter wraps to 0.
  - WAIT_END: in_ready=0. When end_from_next=1, for one cycle drive start_to_next=1, and image_done=1 if bank_sel_write==NUM_BANKS-1. Then go to GUARD.
  - GUARD: one cycle, in_ready=0, end_from_next ignored. This absorbs the consumer's one-cycle-late deassertion of end.
  - GUARD exit: bank_sel_write increments, or wraps to 0 from NUM_BANKS-1. Next state is WRITE if the bank was not the last, else DRAIN.
  - DRAIN: in_ready=0. seen_busy is set when next_ready=0 is sampled. Exit to WRITE when (seen_busy or NUMBER_OF_FILTERS==1) and next_ready=1 and end_from_next=1. seen_busy clears on exit.
- Write path latency: 1 cycle. An accept in cycle t gives mem_write_enable=1 in t+1, with mem_write_address = the addr counter value at t and mem_write_data = in_data at t.
- bank_sel_write remains stable through the last write of its bank; it changes only on GUARD exit.
- Backpressure: in_ready is combinational from state only, and is never dependent on in_valid.
- Simultaneous final accept and end_from_next: the accept completes the bank. The start pulse still takes one WAIT_END cycle, so the minimum bank-done→start gap is 1 cycle.
- Reset mid-bank: all partial writes are abandoned and the next accepted pixel goes to bank 0 address 0. The consumer is reset by the same reset.
- Counter wrap comparisons are on exact terminal values; no out-of-range address is ever driven.

Optional Feature:
- Macro: BANK_WRITER_STALL_CNT_EN.
- When defined:
  - adds output stall_cycles [31:0];
  - counts cycles where in_valid=1 & in_ready=0, saturating at 32'hFFFFFFFF;
  - cleared by reset only.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic fill, IFM_SIZE=3, NUM_BANKS=2, end_from_next held 1, continuous valid:
  - 9 accepts give mem_write_enable on addresses 0..8 of bank 0;
  - start_to_next pulses exactly once, 1 cycle after the 9th accept;
  - bank_sel_write=1 two cycles later.
- Consumer busy: end_from_next=0 after bank 0 fills → in_ready stays 0 and no start is issued. Raising end_from_next causes start_to_next on the next cycle.
- GUARD check: end_from_next held 1 continuously → exactly one start_to_next per bank, never two in consecutive cycles.
- DRAIN with NUMBER_OF_FILTERS=4, using the default parameter set:
  - after bank 5's handoff, image_done=1 and in_ready=0;
  - next_ready stays 1 for 3 cycles, then 0 for 50 cycles, then 1 with end_from_next=1;
  - in_ready returns 1 only after that final condition, and the next write targets bank 0 address 0.
- Reset mid-operation: assert reset after 5 accepts into bank 2 → all outputs take their reset values immediately. The next accept writes bank 0 address 0.
- BANK_WRITER_STALL_CNT_EN build: hold in_valid=1 through a 10-cycle WAIT_END → stall_cycles=10.

Source files
------------

// File: rtl/ifm_bank_writer_cu.sv
// ifm_bank_writer_cu: upstream-side writer for the multi-bank IFM buffer.
// Streams pixels into one bank at a time and hands each filled bank to the
// convolution consumer. It waits for the consumer's end/ready handshake so
// that no bank still being re-read across filter passes is overwritten.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_data    pixel stream from the previous layer
//   in_ready            pixel accepted when in_valid & in_ready (depends on state only)
//   mem_write_*         registered bank write strobe/address/data (1-cycle latency)
//   bank_sel_write      bank being filled; advances once per handoff
//   start_to_next       one-cycle pulse: bank bank_sel_write is complete
//   end_from_next       consumer idle / able to take a start
//   next_ready          consumer is in filter pass 0
//   image_done          one-cycle pulse with the handoff of the last bank
//   stall_cycles        present only with BANK_WRITER_STALL_CNT_EN: saturating count
//                       of cycles with in_valid=1 and in_ready=0
//
// Optional feature macro: BANK_WRITER_STALL_CNT_EN
module ifm_bank_writer_cu #(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE          = 13,
  parameter int NUM_BANKS         = 6,
  parameter int NUMBER_OF_FILTERS = 28,
  parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int BANK_SEL_WIDTH    = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        mem_write_enable,
  output logic [ADDRESS_SIZE_IFM-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  output logic [BANK_SEL_WIDTH-1:0]   bank_sel_write,
  output logic                        start_to_next,
  input  logic                        end_from_next,
  input  logic                        next_ready,
  output logic                        image_done
`ifdef BANK_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_WRITE    = 2'd0,
    ST_WAIT_END = 2'd1,
    ST_GUARD    = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_LAST = ADDRESS_SIZE_IFM'(IFM_SIZE*IFM_SIZE-1);
  localparam logic [BANK_SEL_WIDTH-1:0]   BANK_LAST = BANK_SEL_WIDTH'(NUM_BANKS-1);
  // With a single filter pass the consumer never drops next_ready, so
  // there is no busy period to observe before releasing the writer.
  localparam bit SINGLE_PASS = (NUMBER_OF_FILTERS == 1);

  state_t                      state_q, state_d;
  logic [ADDRESS_SIZE_IFM-1:0] addr_q, addr_d;
  logic [BANK_SEL_WIDTH-1:0]   bank_q, bank_d;
  logic                        seen_busy_q, seen_busy_d;
  logic                        we_q, we_d;
  logic [ADDRESS_SIZE_IFM-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bank_d        = bank_q;
    seen_busy_d   = seen_busy_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    in_ready      = 1'b0;
    start_to_next = 1'b0;
    image_done    = 1'b0;

    case (state_q)
      ST_WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = ST_WAIT_END;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      ST_WAIT_END: begin
        if (end_from_next) begin
          start_to_next = 1'b1;
          image_done    = (bank_q == BANK_LAST);
          state_d       = ST_GUARD;
        end
      end

      // The consumer drops end_from_next one cycle after seeing the start;
      // this cycle keeps that stale high from being taken as a second start.
      ST_GUARD: begin
        if (bank_q == BANK_LAST) begin
          bank_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          bank_d  = bank_q + 1'b1;
          state_d = ST_WRITE;
        end
      end

      // Bank 0 of the next image must not be touched until the consumer has
      // gone through its re-read passes (next_ready low) and come back idle.
      ST_DRAIN: begin
        if (!next_ready) begin
          seen_busy_d = 1'b1;
        end
        if ((seen_busy_q || SINGLE_PASS) && next_ready && end_from_next) begin
          seen_busy_d = 1'b0;
          state_d     = ST_WRITE;
        end
      end

      default: begin
        state_d = ST_WRITE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WRITE;
      addr_q      <= '0;
      bank_q      <= '0;
      seen_busy_q <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      seen_busy_q <= seen_busy_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign mem_write_enable  = we_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdata_q;
  assign bank_sel_write    = bank_q;

`ifdef BANK_WRITER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ifm_bank_writer_cu.sv
module tb_ifm_bank_writer_cu;

  localparam int P_FILL  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_GUARD = 2;
  localparam int P_DRAIN = 3;

  // Reference: pixel-count based view of the writer.
  typedef struct {
    int          s;        // IFM edge
    int          nb;       // banks per image
    int          nf;       // filter passes
    int          ph;
    longint      acc;      // total accepted pixels since reset
    longint      handoffs; // completed bank handoffs since reset
    bit          seen;
    bit          we;
    int          waddr;
    logic [31:0] wdat;
    longint      stall;
  } mdl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: small geometry, single pass
  logic        a_iv, a_end, a_nr, a_rdy, a_we, a_start, a_done;
  logic [31:0] a_dat, a_wdat;
  logic [3:0]  a_waddr;
  logic [0:0]  a_bank;
  // DUT B: default geometry, 4 passes
  logic        b_iv, b_end, b_nr, b_rdy, b_we, b_start, b_done;
  logic [31:0] b_dat, b_wdat;
  logic [7:0]  b_waddr;
  logic [2:0]  b_bank;
`ifdef BANK_WRITER_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  ifm_bank_writer_cu #(.DATA_WIDTH(32), .IFM_SIZE(3), .NUM_BANKS(2), .NUMBER_OF_FILTERS(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_data(a_dat), .in_ready(a_rdy),
    .mem_write_enable(a_we), .mem_write_address(a_waddr), .mem_write_data(a_wdat),
    .bank_sel_write(a_bank), .start_to_next(a_start), .end_from_next(a_end),
    .next_ready(a_nr), .image_done(a_done)
`ifdef BANK_WRITER_STALL_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  ifm_bank_writer_cu #(.NUMBER_OF_FILTERS(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_data(b_dat), .in_ready(b_rdy),
    .mem_write_enable(b_we), .mem_write_address(b_waddr), .mem_write_data(b_wdat),
    .bank_sel_write(b_bank), .start_to_next(b_start), .end_from_next(b_end),
    .next_ready(b_nr), .image_done(b_done)
`ifdef BANK_WRITER_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   a_start_cnt = 0;
  int   b_done_cnt = 0;
  logic a_start_prev = 1'b0;
  mdl_t ma, mb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_init(input int s, input int nb, input int nf);
    mdl_t m;
    m.s = s; m.nb = nb; m.nf = nf;
    m.ph = P_FILL; m.acc = 0; m.handoffs = 0; m.seen = 1'b0;
    m.we = 1'b0; m.waddr = 0; m.wdat = '0; m.stall = 0;
    return m;
  endfunction

  function automatic int mdl_bank(input mdl_t m);
    return int'(m.handoffs % m.nb);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit iv, input bit e, input bit nr,
                                    input logic [31:0] d);
    mdl_t n = m;
    int   words = m.s * m.s;
    n.we = 1'b0;
    if (iv && (m.ph != P_FILL) && (m.stall < 64'hFFFF_FFFF)) n.stall = m.stall + 1;
    case (m.ph)
      P_FILL: if (iv) begin
        n.we    = 1'b1;
        n.waddr = int'(m.acc % words);
        n.wdat  = d;
        n.acc   = m.acc + 1;
        if (n.acc % words == 0) n.ph = P_WAIT;
      end
      P_WAIT: if (e) n.ph = P_GUARD;
      P_GUARD: begin
        n.handoffs = m.handoffs + 1;
        n.ph = (n.handoffs % m.nb == 0) ? P_DRAIN : P_FILL;
      end
      default: begin
        if (!nr) n.seen = 1'b1;
        if ((m.seen || m.nf == 1) && nr && e) begin
          n.ph = P_FILL;
          n.seen = 1'b0;
        end
      end
    endcase
    return n;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance, check registers.
  task automatic cyc();
    bit es;
    #1;
    es = (ma.ph == P_WAIT) && a_end;
    chk("a_in_ready", a_rdy, ma.ph == P_FILL);
    chk("a_start", a_start, es);
    chk("a_image_done", a_done, es && (mdl_bank(ma) == ma.nb - 1));
    chk("a_start_b2b", a_start & a_start_prev, 0);
    es = (mb.ph == P_WAIT) && b_end;
    chk("b_in_ready", b_rdy, mb.ph == P_FILL);
    chk("b_start", b_start, es);
    chk("b_image_done", b_done, es && (mdl_bank(mb) == mb.nb - 1));
    a_start_prev = a_start;
    if (a_start === 1'b1) a_start_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
    @(posedge clk);
    ma = mdl_step(ma, a_iv, a_end, a_nr, a_dat);
    mb = mdl_step(mb, b_iv, b_end, b_nr, b_dat);
    #1;
    chk("a_we", a_we, ma.we);
    if (ma.we) begin
      chk("a_waddr", a_waddr, ma.waddr);
      chk("a_wdata", a_wdat, ma.wdat);
    end
    chk("a_bank", a_bank, mdl_bank(ma));
    chk("b_we", b_we, mb.we);
    if (mb.we) begin
      chk("b_waddr", b_waddr, mb.waddr);
      chk("b_wdata", b_wdat, mb.wdat);
    end
    chk("b_bank", b_bank, mdl_bank(mb));
`ifdef BANK_WRITER_STALL_CNT_EN
    chk("a_stall", a_stall, ma.stall);
    chk("b_stall", b_stall, mb.stall);
`endif
  endtask

  // Asynchronous reset: outputs must take reset values without a clock edge.
  task automatic do_reset();
    a_iv = 1'b0;
    b_iv = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_a_in_ready", a_rdy, 1);
    chk("rst_a_we", a_we, 0);
    chk("rst_a_waddr", a_waddr, 0);
    chk("rst_a_wdata", a_wdat, 0);
    chk("rst_a_bank", a_bank, 0);
    chk("rst_a_start", a_start, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_in_ready", b_rdy, 1);
    chk("rst_b_we", b_we, 0);
    chk("rst_b_waddr", b_waddr, 0);
    chk("rst_b_wdata", b_wdat, 0);
    chk("rst_b_bank", b_bank, 0);
    chk("rst_b_start", b_start, 0);
    chk("rst_b_done", b_done, 0);
`ifdef BANK_WRITER_STALL_CNT_EN
    chk("rst_b_stall", b_stall, 0);
`endif
    ma = mdl_init(3, 2, 1);
    mb = mdl_init(13, 6, 4);
    a_start_prev = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_iv = 0; a_end = 0; a_nr = 1; a_dat = '0;
    b_iv = 0; b_end = 0; b_nr = 1; b_dat = '0;
    do_reset();

    // Basic fill of A bank 0, consumer idle throughout
    a_end = 1'b1;
    a_iv  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_dat = $urandom;
      cyc();
    end
    chk("fill_no_early_start", a_start_cnt, 0);
    cyc();                                   // WAIT_END: start pulse
    chk("fill_start_once", a_start_cnt, 1);
    chk("fill_bank_held", a_bank, 0);
    a_iv = 1'b0;
    cyc();                                   // GUARD
    chk("fill_bank_next", a_bank, 1);
    chk("fill_start_still_once", a_start_cnt, 1);

    // Consumer busy: bank 1 fills while end_from_next is low
    a_end = 1'b0;
    a_iv  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_dat = $urandom;
      cyc();
    end
    for (int i = 0; i < 6; i++) cyc();
    chk("busy_in_ready_low", a_rdy, 0);
    chk("busy_no_start", a_start_cnt, 1);
    a_end = 1'b1;
    cyc();
    chk("busy_start_on_end", a_start_cnt, 2);
    a_iv = 1'b0;

    // Random traffic on A: first end held high, then random handshake
    for (int i = 0; i < 60; i++) begin
      a_iv  = 1'($urandom_range(0, 1));
      a_dat = $urandom;
      cyc();
    end
    for (int i = 0; i < 150; i++) begin
      a_iv  = ($urandom_range(0, 9) < 7);
      a_end = 1'($urandom_range(0, 1));
      a_nr  = 1'($urandom_range(0, 1));
      a_dat = $urandom;
      cyc();
    end
    a_iv = 1'b0; a_end = 1'b0; a_nr = 1'b1;

    // DRAIN on B: fill a whole image with the consumer idle
    b_end = 1'b1;
    b_nr  = 1'b1;
    b_iv  = 1'b1;
    for (int i = 0; i < 1200 && b_done_cnt == 0; i++) begin
      b_dat = $urandom;
      cyc();
    end
    chk("drain_image_done_seen", b_done_cnt, 1);
    chk("drain_in_ready_low", b_rdy, 0);
    for (int i = 0; i < 3; i++) cyc();
    chk("drain_not_released_early", b_rdy, 0);
    b_nr = 1'b0;
    for (int i = 0; i < 50; i++) cyc();
    chk("drain_held_while_busy", b_rdy, 0);
    b_nr = 1'b1;
    cyc();
    chk("drain_released", b_rdy, 1);
    b_dat = $urandom;
    cyc();
    chk("drain_first_we", b_we, 1);
    chk("drain_first_addr", b_waddr, 0);
    chk("drain_first_bank", b_bank, 0);

    // Reset in the middle of B bank 2 after 5 accepts
    for (int i = 0; i < 1000 && !(mdl_bank(mb) == 2 && mb.acc % 169 == 5); i++) begin
      b_dat = $urandom;
      cyc();
    end
    chk("rst_mid_reached", (mdl_bank(mb) == 2 && mb.acc % 169 == 5), 1);
    chk("rst_mid_bank_before", b_bank, 2);
    do_reset();
    b_iv  = 1'b1;
    b_dat = $urandom;
    cyc();
    chk("rst_mid_next_we", b_we, 1);
    chk("rst_mid_next_addr", b_waddr, 0);
    chk("rst_mid_next_bank", b_bank, 0);

    // Stall window: pixel offered throughout a 10-cycle WAIT_END
    b_end = 1'b0;
    for (int i = 0; i < 400 && mb.ph == P_FILL; i++) begin
      b_dat = $urandom;
      cyc();
    end
    for (int i = 0; i < 10; i++) cyc();
    chk("stall_window_ready_low", b_rdy, 0);
`ifdef BANK_WRITER_STALL_CNT_EN
    chk("stall_cycles_10", b_stall, 10);
`endif
    b_end = 1'b1;
    cyc();
    b_iv = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
